uart_tx_fifo_frame: RTL

Parametrised UART transmitter. Replaces the fixed 8N1, edge-triggered UART TX path. Adds a valid/ready input handshake into an internal FIFO, compile-time data width, optional parity and 1 or 2 stop bits. Transmits queued frames back-to-back with no idle gap. Sits between the command/report logic and the board TX pin, in the uart_tx_clk domain.

---
 rtl/uart_tx_fifo_frame.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo_frame.sv
// UART transmitter with a valid/ready input FIFO, configurable data width, parity and stop bits.
// Queued frames are sent back-to-back; the serial line is driven from a flop.
module uart_tx_fifo_frame #(
  parameter logic [31:0] CLK_FREQ   = 32'd50_000_000,
  parameter logic [31:0] UART_BAUD  = 32'd115200,
  parameter int          DATA_BITS  = 8,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                               uart_tx_clk,
  input  logic                               reset_n,
  input  logic [DATA_BITS-1:0]               tx_data,
  input  logic                               tx_valid,
  output logic                               tx_ready,
  output logic                               tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               uart_tx_path
);

  localparam int BAUD_RATE_CNT = int'(CLK_FREQ / UART_BAUD);
  localparam int CNT_W = $clog2(BAUD_RATE_CNT);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int BIT_W = 4;

  typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;

  localparam state_t AFTER_DATA = (PARITY != 0) ? ST_PARITY : ST_STOP;

  state_t               state_reg, state_next;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_reg, rd_ptr_reg;
  logic [LVL_W-1:0]     level_reg;
  logic [CNT_W-1:0]     cnt_reg, cnt_next;
  logic [BIT_W-1:0]     bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic                 parity_reg, parity_next;
  logic                 line_reg, line_next;
  logic                 push, pop, bit_done, fifo_empty, head_par;
  logic [DATA_BITS-1:0] head;

  assign tx_ready     = (level_reg != LVL_W'(FIFO_DEPTH));
  assign push         = tx_valid && tx_ready;
  assign fifo_empty   = (level_reg == '0);
  assign head         = mem[rd_ptr_reg];
  assign head_par     = (PARITY == 1) ? ~(^head) : (^head);
  assign bit_done     = (cnt_reg == CNT_W'(BAUD_RATE_CNT - 1));
  assign fifo_level   = level_reg;
  assign tx_busy      = (state_reg != ST_IDLE) || !fifo_empty;
  assign uart_tx_path = line_reg;

  // Storage carries no reset: unread entries are don't-care.
  always_ff @(posedge uart_tx_clk) begin
    if (push) mem[wr_ptr_reg] <= tx_data;
  end

  always_ff @(posedge uart_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LVL_W'(1);
        2'b01:   level_reg <= level_reg - LVL_W'(1);
        default: level_reg <= level_reg;
      endcase
    end
  end

  always_ff @(posedge uart_tx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= ST_IDLE;
      cnt_reg     <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      parity_reg  <= 1'b0;
      line_reg    <= 1'b1;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      parity_reg  <= parity_next;
      line_reg    <= line_next;
    end
  end

  // The line flop follows the current state, so it lags the FSM by one cycle.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = bit_done ? '0 : cnt_reg + CNT_W'(1);
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    parity_next  = parity_reg;
    line_next    = 1'b1;
    pop          = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        cnt_next = '0;
        if (!fifo_empty) begin
          pop          = 1'b1;
          shift_next   = head;
          parity_next  = head_par;
          bit_idx_next = '0;
          state_next   = ST_START;
        end
      end
      ST_START: begin
        line_next = 1'b0;
        if (bit_done) begin
          bit_idx_next = '0;
          state_next   = ST_DATA;
        end
      end
      ST_DATA: begin
        line_next = shift_reg[0];
        if (bit_done) begin
          shift_next = shift_reg >> 1;
          if (bit_idx_reg == BIT_W'(DATA_BITS - 1)) begin
            bit_idx_next = '0;
            state_next   = AFTER_DATA;
          end else begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
          end
        end
      end
      ST_PARITY: begin
        line_next = parity_reg;
        if (bit_done) begin
          bit_idx_next = '0;
          state_next   = ST_STOP;
        end
      end
      ST_STOP: begin
        line_next = 1'b1;
        if (bit_done) begin
          if (bit_idx_reg == BIT_W'(STOP_BITS - 1)) begin
            bit_idx_next = '0;
            // Chain straight into the next start bit when data is waiting.
            if (!fifo_empty) begin
              pop         = 1'b1;
              shift_next  = head;
              parity_next = head_par;
              state_next  = ST_START;
            end else begin
              state_next  = ST_IDLE;
            end
          end else begin
            bit_idx_next = bit_idx_reg + BIT_W'(1);
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule
